// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: datapath width and the memory/write-back stage state type.
package rv32i_pkg;

  localparam int DPW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mwb_state_e;

endpackage

// File: rtl/mem_wb_stage.sv
// Memory-access and write-back stage: word loads/stores over a ready/valid data port,
// register-file write-back, and an upstream stall while a memory access is in flight.
module mem_wb_stage #(
  parameter int DPW = rv32i_pkg::DPW,
  parameter int ADW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           validM,
  input  logic           regwriteM,
  input  logic           resultsrcM,
  input  logic           memwriteM,
  input  logic [DPW-1:0] aluresultM,
  input  logic [DPW-1:0] Rd2M,
  input  logic [ADW-1:0] RdM,
  output logic           stallM,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DPW-1:0] dmem_addr,
  output logic [DPW-1:0] dmem_wdata,
  input  logic           dmem_ready,
  input  logic           dmem_rvalid,
  input  logic [DPW-1:0] dmem_rdata,
  output logic           we,
  output logic [ADW-1:0] addr_3,
  output logic [DPW-1:0] wd_3
);
  import rv32i_pkg::*;

  mwb_state_e     r_state;
  logic [DPW-3:0] r_addr;
  logic [DPW-1:0] r_wdata;
  logic [ADW-1:0] r_rd;
  logic           r_is_store;
  logic           r_regwrite;
  logic           r_we;
  logic [ADW-1:0] r_addr_3;
  logic [DPW-1:0] r_wd_3;

  logic w_mem_op;
  logic w_rd_nz;
  logic w_cap_rd_nz;

  assign w_mem_op    = validM && (memwriteM || resultsrcM);
  assign w_rd_nz     = (RdM != '0);
  assign w_cap_rd_nz = (r_rd != '0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_is_store <= 1'b0;
      r_regwrite <= 1'b0;
      r_we       <= 1'b0;
      r_addr_3   <= '0;
      r_wd_3     <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_mem_op) begin
            r_addr     <= aluresultM[DPW-1:2];
            r_wdata    <= Rd2M;
            r_rd       <= RdM;
            r_is_store <= memwriteM;
            r_regwrite <= regwriteM;
            r_state    <= REQ;
          end else if (validM && regwriteM && w_rd_nz) begin
            r_we     <= 1'b1;
            r_addr_3 <= RdM;
            r_wd_3   <= aluresultM;
          end
        end
        REQ: begin
          if (dmem_ready) r_state <= r_is_store ? IDLE : WAIT;
        end
        WAIT: begin
          // Writes to x0 are dropped here, after the handshake has still completed.
          if (dmem_rvalid) begin
            r_we     <= r_regwrite && w_cap_rd_nz;
            r_addr_3 <= r_rd;
            r_wd_3   <= dmem_rdata;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    stallM     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    case (r_state)
      IDLE: stallM = w_mem_op;
      REQ: begin
        dmem_req   = 1'b1;
        dmem_we    = r_is_store;
        dmem_addr  = {r_addr, 2'b00};
        dmem_wdata = r_wdata;
        stallM     = !(dmem_ready && r_is_store);
      end
      WAIT:    stallM = !dmem_rvalid;
      default: stallM = 1'b0;
    endcase
  end

  assign we     = r_we;
  assign addr_3 = r_addr_3;
  assign wd_3   = r_wd_3;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: transaction-level schedule of expected outputs
// per cycle, a memory model, directed cases and randomized instruction streams.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        validM, regwriteM, resultsrcM, memwriteM;
  logic [31:0] aluresultM, Rd2M;
  logic [4:0]  RdM;
  logic        stallM, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        we;
  logic [4:0]  addr_3;
  logic [31:0] wd_3;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst),
    .validM(validM), .regwriteM(regwriteM), .resultsrcM(resultsrcM), .memwriteM(memwriteM),
    .aluresultM(aluresultM), .Rd2M(Rd2M), .RdM(RdM),
    .stallM(stallM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .we(we), .addr_3(addr_3), .wd_3(wd_3)
  );

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle, plus the write-back due next cycle.
  logic        chk_en;
  logic        e_stall, e_req, e_dwe, e_we;
  logic [31:0] e_daddr, e_dwdata, e_wd3;
  logic [4:0]  e_a3;
  logic        n_we;
  logic [4:0]  n_a3;
  logic [31:0] n_wd3;

  logic [31:0] mem [logic [29:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("stallM", stallM, e_stall);
      check("dmem_req", dmem_req, e_req);
      if (e_req) begin
        check("dmem_we", dmem_we, e_dwe);
        check("dmem_addr", dmem_addr, e_daddr);
        check("dmem_wdata", dmem_wdata, e_dwdata);
      end
      check("we", we, e_we);
      if (e_we) begin
        check("addr_3", addr_3, e_a3);
        check("wd_3", wd_3, e_wd3);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    e_we = n_we; e_a3 = n_a3; e_wd3 = n_wd3; n_we = 1'b0;
    e_stall = 1'b0; e_req = 1'b0; e_dwe = 1'b0; e_daddr = '0; e_dwdata = '0;
    dmem_ready  = 1'($urandom_range(0, 1));
    dmem_rvalid = 1'($urandom_range(0, 1));
    dmem_rdata  = $urandom;
  endtask

  task automatic idle();
    step();
    validM = 1'b0;
    regwriteM = 1'($urandom_range(0, 1)); resultsrcM = 1'($urandom_range(0, 1));
    memwriteM = 1'($urandom_range(0, 1));
    aluresultM = $urandom; Rd2M = $urandom; RdM = 5'($urandom);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] val, input logic regw);
    step();
    validM = 1'b1; regwriteM = regw; resultsrcM = 1'b0; memwriteM = 1'b0;
    aluresultM = val; Rd2M = $urandom; RdM = rd;
    if (regw && rd != 5'd0) begin
      n_we = 1'b1; n_a3 = rd; n_wd3 = val;
    end
  endtask

  // d = REQ cycles before ready, e = WAIT cycles before rvalid; inputs held while stalled.
  task automatic mem_op(input logic is_store, input logic [4:0] rd, input logic [31:0] addr,
                        input logic [31:0] data, input int d, input int e);
    step();
    validM = 1'b1; regwriteM = !is_store; resultsrcM = !is_store; memwriteM = is_store;
    aluresultM = addr; Rd2M = data; RdM = rd;
    e_stall = 1'b1;
    for (int i = 0; i <= d; i++) begin
      step();
      dmem_ready = (i == d);
      e_req = 1'b1; e_dwe = is_store; e_daddr = {addr[31:2], 2'b00}; e_dwdata = data;
      e_stall = !(i == d && is_store);
    end
    if (is_store) begin
      mem[addr[31:2]] = data;
    end else begin
      for (int j = 0; j <= e; j++) begin
        step();
        dmem_rvalid = (j == e);
        e_stall = (j != e);
        if (j == e) begin
          dmem_rdata = mem_rd(addr);
          if (rd != 5'd0) begin
            n_we = 1'b1; n_a3 = rd; n_wd3 = dmem_rdata;
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int k;
    chk_en = 1'b0; rst = 1'b1;
    validM = 0; regwriteM = 0; resultsrcM = 0; memwriteM = 0;
    aluresultM = '0; Rd2M = '0; RdM = '0;
    dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = '0;
    n_we = 0; n_a3 = '0; n_wd3 = '0;
    e_stall = 0; e_req = 0; e_dwe = 0; e_daddr = '0; e_dwdata = '0; e_we = 0; e_a3 = '0; e_wd3 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_we", we, 0);
    check("rst_addr_3", addr_3, 0);
    check("rst_wd_3", wd_3, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    check("rst_dmem_wdata", dmem_wdata, 0);
    chk_en = 1'b1;

    // ALU write-back, pinned by literals.
    alu(5'd7, 32'h0000_1234, 1'b1);
    idle();
    @(negedge clk);
    check("lit_alu_we", we, 1);
    check("lit_alu_addr_3", addr_3, 7);
    check("lit_alu_wd_3", wd_3, 32'h0000_1234);

    // Store with ready after two REQ cycles.
    mem_op(1'b1, 5'd9, 32'h0000_0043, 32'hDEAD_BEEF, 1, 0);
    @(negedge clk);
    check("lit_st_addr", dmem_addr, 32'h0000_0040);
    check("lit_st_wdata", dmem_wdata, 32'hDEAD_BEEF);
    check("lit_st_stall", stallM, 0);
    idle();

    // Load: ready immediately, rvalid three cycles after ready.
    mem[30'h20] = 32'hCAFE_0001;
    mem_op(1'b0, 5'd12, 32'h0000_0080, $urandom, 0, 2);
    idle();
    @(negedge clk);
    check("lit_ld_we", we, 1);
    check("lit_ld_addr_3", addr_3, 12);
    check("lit_ld_wd_3", wd_3, 32'hCAFE_0001);

    // Destination x0: no write-back, handshake still completes.
    alu(5'd0, $urandom, 1'b1);
    mem_op(1'b0, 5'd0, 32'h0000_0044, $urandom, 1, 1);
    idle();

    // Stray rvalid while idle.
    idle(); dmem_rvalid = 1'b1;
    idle(); dmem_rvalid = 1'b1;
    idle();

    // Reset while waiting for read data.
    step();
    validM = 1'b1; regwriteM = 1'b1; resultsrcM = 1'b1; memwriteM = 1'b0;
    aluresultM = 32'h0000_0080; Rd2M = $urandom; RdM = 5'd15;
    e_stall = 1'b1;
    step();
    dmem_ready = 1'b1; e_req = 1'b1; e_dwe = 1'b0; e_daddr = 32'h0000_0080; e_dwdata = Rd2M;
    e_stall = 1'b1;
    step();
    dmem_rvalid = 1'b0; e_stall = 1'b1;
    step();
    chk_en = 1'b0; rst = 1'b1; dmem_rvalid = 1'b0;
    step();
    rst = 1'b0; validM = 1'b0; dmem_rvalid = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rstw_dmem_addr", dmem_addr, 0);
    check("rstw_dmem_wdata", dmem_wdata, 0);
    check("rstw_addr_3", addr_3, 0);
    idle(); dmem_rvalid = 1'b1;
    idle();

    // Back-to-back load, ALU, store.
    mem_op(1'b0, 5'd3, 32'h0000_0080, $urandom, 0, 0);
    alu(5'd4, 32'h0BAD_F00D, 1'b1);
    mem_op(1'b1, 5'd0, 32'h0000_0048, 32'h1357_9BDF, 0, 0);
    mem_op(1'b0, 5'd5, 32'h0000_004B, $urandom, 0, 0);
    idle();

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 3);
      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      case (k)
        0: idle();
        1: alu(5'($urandom), $urandom, 1'($urandom_range(0, 1)));
        2: mem_op(1'b1, 5'($urandom), a, $urandom, $urandom_range(0, 2), 0);
        default: mem_op(1'b0, 5'($urandom), a, $urandom, $urandom_range(0, 2), $urandom_range(0, 3));
      endcase
    end
    idle();
    idle();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and write-back stage of the rv32i pipeline. It consumes the M-stage control and data outputs of the execute pipeline (`regwriteM`, `resultsrcM`, `memwriteM`, `aluresultM`, `Rd2M`, `RdM`) and runs word loads and stores over a ready/valid data-memory port. It drives the register-file write port (`we`, `addr_3`, `wd_3`), which closes the loop back into the decode-stage register file. It stalls the upstream pipeline while a memory transaction is outstanding.

## Interface
Parameters:
- `DPW`, default `rv32i_pkg::DPW` (32): datapath width.
- `ADW`, default 5: register address width.

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  synchronous, active-high reset.
- `validM`  in  1  M-stage inputs carry a live instruction.
- `regwriteM`  in  1  instruction writes `RdM`.
- `resultsrcM`  in  1  1 = load (result from memory); 0 = ALU result.
- `memwriteM`  in  1  store.
- `aluresultM`  in  DPW  ALU result, or the memory address for loads and stores.
- `Rd2M`  in  DPW  store data.
- `RdM`  in  ADW  destination register.
- `stallM`  out  1  upstream must hold the M-stage inputs.
- `dmem_req`  out  1  memory request valid.
- `dmem_we`  out  1  request is a write.
- `dmem_addr`  out  DPW  word-aligned byte address.
- `dmem_wdata`  out  DPW  write data.
- `dmem_ready`  in  1  memory accepts the request this cycle.
- `dmem_rvalid`  in  1  read data valid.
- `dmem_rdata`  in  DPW  read data.
- `we`  out  1  register-file write enable.
- `addr_3`  out  ADW  register-file write address.
- `wd_3`  out  DPW  register-file write data.

## Operation
- FSM states: `IDLE`, `REQ`, `WAIT`.
- Memory op: `validM && (memwriteM || resultsrcM)`.
- `IDLE`:
  - On a memory op, capture `aluresultM`, `Rd2M`, `RdM`, `memwriteM` and `regwriteM`, then go to `REQ`.
  - On a valid non-memory op with `regwriteM`, register a write-back: `addr_3 = RdM`, `wd_3 = aluresultM`.
- `REQ`:
  - Drive `dmem_req = 1`, `dmem_we` = captured `memwriteM`, `dmem_addr = {addr[DPW-1:2], 2'b00}`, `dmem_wdata` = captured `Rd2M`.
  - Outputs stay stable until `dmem_ready`.
  - On `dmem_ready`: a store returns to `IDLE` with no write-back; a load goes to `WAIT`.
- `WAIT`: on `dmem_rvalid`, register a write-back of `dmem_rdata` to the captured `RdM`, then go to `IDLE`.
- `dmem_rvalid` outside `WAIT` is ignored.
- `we` is never asserted when the destination is x0 (address 0), whether from `RdM` or the captured `RdM`.
- `stallM = 1` in all of these cases:
  - in `IDLE` with a memory op present;
  - in `REQ`, except the store-completion cycle (`dmem_ready && dmem_we`);
  - in `WAIT`, except the cycle with `dmem_rvalid`.
- The completion cycle has `stallM = 0`, so upstream advances and the next instruction is seen in `IDLE` on the following cycle.
- Address bits [1:0] are ignored. Only word accesses are supported.

## Timing
- Reset (`rst` sampled high at an edge): state `IDLE`; `we`, `addr_3`, `wd_3`, `dmem_req`, `dmem_we`, `dmem_addr` and `dmem_wdata` all 0.
- Reset mid-transaction abandons the transaction: `dmem_req` is low from the next cycle and no write-back occurs.
- ALU write-back: `we` is high for exactly 1 cycle, the cycle after the edge that sampled `validM`.
- Store:
  - `dmem_req` rises 1 cycle after `validM` is sampled.
  - Minimum occupancy is 2 cycles, with `dmem_ready` in the first `REQ` cycle.
- Load:
  - Best case is 3 cycles from `validM` to `we`: `REQ` (ready), then `WAIT` (rvalid), then the write-back cycle.
  - `wd_3 = dmem_rdata` as sampled.
- `we` is a one-cycle pulse per write-back and is never high on two consecutive cycles for the same instruction.

## Structure
- `rv32i_pkg` holds `DPW` and a new `mwb_state_e` enum (`IDLE`, `REQ`, `WAIT`).
- Single module, no sub-module; the FSM and the capture registers are local.
- `top` instantiates it after the execute/memory pipeline register and wires `we`, `addr_3` and `wd_3` to the register file.

## Test plan
- ALU write-back: `validM=1`, `regwriteM=1`, `resultsrcM=0`, `RdM=7`, `aluresultM=32'h0000_1234` -> next cycle `we=1`, `addr_3=7`, `wd_3=32'h1234`; `stallM` stays 0.
- Store with 2-cycle ready delay: `memwriteM=1`, `aluresultM=32'h0000_0043`, `Rd2M=32'hDEAD_BEEF`:
  - `dmem_req=1`, `dmem_we=1`, `dmem_addr=32'h40`, `dmem_wdata=32'hDEAD_BEEF`, all held for 2 cycles;
  - `we` stays 0;
  - `stallM` is low only on the ready cycle.
- Load: `resultsrcM=1`, `RdM=12`, address `32'h80`, `rvalid` 3 cycles after ready with `dmem_rdata=32'hCAFE_0001` -> one `we` pulse with `addr_3=12`, `wd_3=32'hCAFE_0001`; `stallM` high throughout the wait.
- x0 suppression: ALU op and load with `RdM=0` -> `we` never asserted; the load still completes its memory handshake.
- Stray `dmem_rvalid=1` in `IDLE` -> no `we`; reset during `WAIT` -> all outputs 0 next cycle and a later `rvalid` is ignored.
- Back-to-back sequence load, ALU op, store -> each completes in order with correct `we` and `addr_3` values and no lost or duplicated write-back.
